// File: rtl/text_font_pkg.sv
// Font ROM geometry shared by the font ROM, the text render blocks and the font arbiter.
package text_font_pkg;

  localparam int unsigned FONT_CHAR_W  = 7;
  localparam int unsigned FONT_ROW_W   = 4;
  localparam int unsigned FONT_GLYPH_W = 8;
  localparam int unsigned FONT_ADDR_W  = FONT_CHAR_W + FONT_ROW_W;

  // Font ROM address layout: char code in the upper bits, glyph row in the lower bits.
  function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [FONT_CHAR_W-1:0] char_code,
                                                       input logic [FONT_ROW_W-1:0]  row);
    return {char_code, row};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/text_font_arbiter.sv
// Round-robin sharing of the font-glyph ROM among text requesters; responses are
// tagged back to the issuing requester after a fixed ROM_LATENCY+2 cycle pipeline.
module text_font_arbiter
  import text_font_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CHAR_W      = FONT_CHAR_W,
  parameter int unsigned ROW_W       = FONT_ROW_W,
  parameter int unsigned GLYPH_W     = FONT_GLYPH_W,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CHAR_W-1:0] req_char,
  input  logic [NUM_REQ*ROW_W-1:0]  req_row,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rom_en,
  output logic [CHAR_W+ROW_W-1:0]   rom_addr,
  input  logic [GLYPH_W-1:0]        rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [GLYPH_W-1:0]        rsp_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]                rr_ptr;
  logic [NUM_REQ-1:0]              grant;
  logic [IDX_W-1:0]                grant_idx;
  logic                            grant_any;
  logic [CHAR_W-1:0]               sel_char;
  logic [ROW_W-1:0]                sel_row;
  logic [ROM_LATENCY:0]            tag_vld;
  logic [ROM_LATENCY:0][IDX_W-1:0] tag_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No grants are handed out while reset is held.
  assign req_ready = rst_n ? grant : '0;
  assign grant_any = |req_ready;
  assign sel_char  = req_char[32'(grant_idx)*CHAR_W +: CHAR_W];
  assign sel_row   = req_row[32'(grant_idx)*ROW_W +: ROW_W];

  // Pointer advance and ROM issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= grant_any;
      if (grant_any) begin
        rom_addr <= {sel_char, sel_row};
        rr_ptr   <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // Tag pipe: last stage lines up with rom_data for the corresponding issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[ROM_LATENCY-1:0], grant_any};
      tag_id  <= {tag_id[ROM_LATENCY-1:0], grant_idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld[ROM_LATENCY] ? (NUM_REQ'(1) << tag_id[ROM_LATENCY]) : '0;
      if (tag_vld[ROM_LATENCY]) rsp_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_text_font_arbiter.sv
// Directed and randomized scoreboard bench for text_font_arbiter with a 2-cycle ROM model.
module tb_text_font_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_char;
  logic [15:0] req_row;
  logic [3:0]  req_ready;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;

  int tests = 0;
  int fails = 0;

  text_font_arbiter #(
    .NUM_REQ(4), .CHAR_W(7), .ROW_W(4), .GLYPH_W(8), .ROM_LATENCY(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_char  (req_char),
    .req_row   (req_row),
    .req_ready (req_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [10:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Font ROM model: data valid two cycles after rom_en.
  logic [7:0] rom_p1, rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_en ? glyph(rom_addr) : 8'h00;
    rom_p2 <= rom_p1;
  end
  assign rom_data = rom_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] c, input logic [3:0] r);
    req_char[i*7 +: 7] = c;
    req_row[i*4 +: 4]  = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         due;
    logic [3:0] id;
    logic [7:0] data;
  } exp_t;

  // Expected glyph rows for char 0x10+i, row i.
  logic [7:0] data_tab [4] = '{8'hA5, 8'hB4, 8'h87, 8'h96};

  exp_t       q[$];
  logic [3:0] pend;
  logic [3:0] obs_ready;
  int         wait_cnt [4];
  logic [6:0] rc [4];
  logic [3:0] rr [4];
  logic [3:0] exp_v;
  logic [7:0] exp_d;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_char  = '0;
    req_row   = '0;
    pend      = '0;

    // Reset with all requesters valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_rom_addr", rom_addr, 11'h000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 8'h00);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    // Single requester, char 0x41 row 3
    @(negedge clk);
    set_req(2, 7'h41, 4'h3);
    req_valid = 4'b0100;
    #1 chk("single_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("single_rom_en", rom_en, 1'b1);
    chk("single_rom_addr", rom_addr, 11'h413);
    @(negedge clk);
    #1;
    chk("single_rom_en_off", rom_en, 1'b0);
    chk("single_addr_hold", rom_addr, 11'h413);
    @(negedge clk);
    #1 chk("single_rsp_early", rsp_valid, 4'b0000);
    @(negedge clk);
    #1;
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 8'hB6);
    @(negedge clk);
    #1;
    chk("single_rsp_once", rsp_valid, 4'b0000);
    chk("single_data_hold", rsp_data, 8'hB6);
    chk("single_ptr", 32'(dut.rr_ptr), 32'd3);

    // All four valid for 8 cycles after a pointer reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 7'(7'h10 + i), 4'(i));
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_v = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      chk("all_ready", req_ready, exp_v);
      exp_v = (c >= 4) ? 4'(1 << ((c - 4) % 4)) : 4'h0;
      chk("all_rsp_valid", rsp_valid, exp_v);
      if (c >= 4) chk("all_rsp_data", rsp_data, data_tab[(c - 4) % 4]);
      @(negedge clk);
    end

    // Wrap-around: drive pointer to 3, then only requester 0
    req_valid = 4'b0100;
    #1 chk("wrap_pre_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("wrap_ptr3", 32'(dut.rr_ptr), 32'd3);
    chk("wrap_ready0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    chk("wrap_ptr1", 32'(dut.rr_ptr), 32'd1);
    chk("wrap_ready1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    #1 chk("wrap_ready3", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);

    // Reset while three requests are in flight
    #1 chk("midrst_ptr0", 32'(dut.rr_ptr), 32'd0);
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("midrst_ready", req_ready, 4'(1 << k));
      @(negedge clk);
    end
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    chk("midrst_rom_en", rom_en, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("midrst_no_rsp", rsp_valid, 4'b0000);
      @(negedge clk);
    end
    chk("midrst_ptr_after", 32'(dut.rr_ptr), 32'd0);

    // Random sweep with scoreboard and starvation bound
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (cyc < 2990 && !pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]     = 1'b1;
          rc[i]       = 7'($urandom);
          rr[i]       = 4'($urandom);
          wait_cnt[i] = 0;
          set_req(i, rc[i], rr[i]);
        end
      end
      req_valid = pend;
      #1;
      obs_ready = req_ready;
      chk("rnd_ready_legal", 32'(((obs_ready & ~pend) == 4'h0) && $onehot0(obs_ready)), 32'd1);
      exp_v = 4'h0;
      exp_d = 8'h00;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_v = q[0].id;
        exp_d = q[0].data;
        void'(q.pop_front());
      end
      chk("rnd_rsp_valid", rsp_valid, exp_v);
      if (exp_v != 4'h0) chk("rnd_rsp_data", rsp_data, exp_d);
      for (int i = 0; i < 4; i++) begin
        if (obs_ready[i]) begin
          q.push_back('{cyc + 4, 4'(1 << i), glyph({rc[i], rr[i]})});
          chk("rnd_starve", 32'(wait_cnt[i] < 4), 32'd1);
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          wait_cnt[i]++;
        end
      end
      @(negedge clk);
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
